// File: rtl/vector_op_master_if.sv
// Avalon-MM master bus bundle between vector_op_master and the vector
// accumulate register-file slave.
//   master_address/read/write/writedata : command, driven by the master
//   master_readdata                     : zero-latency read data from the slave
//   master_waitrequest                  : slave stall
interface vector_op_master_if #(
    parameter int ADDRESS_WIDTH = 3
);
    logic [ADDRESS_WIDTH-1:0] master_address;
    logic                     master_read;
    logic [31:0]              master_readdata;
    logic                     master_write;
    logic [31:0]              master_writedata;
    logic                     master_waitrequest;

    modport master (
        output master_address, master_read, master_write, master_writedata,
        input  master_readdata, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_write, master_writedata,
        output master_readdata, master_waitrequest
    );
endinterface

// File: rtl/vector_op_master.sv
// Avalon-MM master that runs one job on the vector accumulate peripheral:
// operand writes, CTRL=ACTIVE, wait for done_irq (with watchdog), RESULT read,
// CTRL=IDLE. The result is presented with a one-cycle valid pulse.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : job request, accepted only while IDLE
//   operands      : NUM_OPERANDS packed 32-bit words, latched on accept
//   busy          : high while a job is in flight
//   result        : last RESULT read, result_valid pulses when it updates
//   timeout_err   : sticky watchdog abort flag, cleared by the next accept
//   bus           : Avalon-MM master port
//   done_irq      : level done interrupt from the slave
module vector_op_master #(
    parameter int ADDRESS_WIDTH  = 3,
    parameter int NUM_OPERANDS   = 4,
    parameter int CTRL_ADDR      = 0,
    parameter int RESULT_ADDR    = 1,
    parameter int OPERAND_BASE   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [32*NUM_OPERANDS-1:0] operands,
    output logic                       busy,
    output logic [31:0]                result,
    output logic                       result_valid,
    output logic                       timeout_err,
    vector_op_master_if.master         bus,
    input  logic                       done_irq
);
    localparam int IDX_W = $clog2(NUM_OPERANDS + 1);
    localparam int SEL_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_OP, WR_START, WAIT_IRQ, SETTLE, RD_RESULT, WR_CLEAR
    } state_t;

    typedef struct packed {
        logic                     rd;
        logic                     wr;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [31:0]              data;
    } cmd_t;

    state_t                        state_q, state_d;
    logic [NUM_OPERANDS-1:0][31:0] ops_q, ops_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [WD_W-1:0]               wdog_q, wdog_d;
    logic                          abort_q, abort_d;
    logic                          terr_q, terr_d;
    logic [31:0]                   res_q, res_d;
    logic                          rvld_q, rvld_d;
    cmd_t                          cmd_q, cmd_d;
    logic                          xfer_done;

    assign xfer_done = (cmd_q.rd | cmd_q.wr) & ~bus.master_waitrequest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ops_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            abort_q <= 1'b0;
            terr_q  <= 1'b0;
            res_q   <= '0;
            rvld_q  <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            abort_q <= abort_d;
            terr_q  <= terr_d;
            res_q   <= res_d;
            rvld_q  <= rvld_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        abort_d = abort_q;
        terr_d  = terr_q;
        res_d   = res_q;
        rvld_d  = 1'b0;
        cmd_d   = '0;

        case (state_q)
            IDLE: if (start) begin
                ops_d   = operands;
                terr_d  = 1'b0;
                abort_d = 1'b0;
                idx_d   = '0;
                state_d = WR_OP;
            end
            WR_OP: if (xfer_done) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_OPERANDS - 1)) state_d = WR_START;
            end
            WR_START: if (xfer_done) begin
                wdog_d  = '0;
                state_d = WAIT_IRQ;
            end
            WAIT_IRQ: begin
                // A stale irq on entry is taken as done; the clear-write keeps
                // that from happening in normal flow.
                if (done_irq) begin
                    state_d = SETTLE;
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = WR_CLEAR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            // Slave updates RESULT one cycle after raising done_irq.
            SETTLE: state_d = RD_RESULT;
            RD_RESULT: if (xfer_done) begin
                res_d   = bus.master_readdata;
                state_d = WR_CLEAR;
            end
            WR_CLEAR: if (xfer_done) begin
                rvld_d  = ~abort_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Command is a function of the next state, so it is registered and
        // naturally holds while a stall keeps state/idx unchanged.
        case (state_d)
            WR_OP: begin
                cmd_d.wr   = 1'b1;
                cmd_d.addr = ADDRESS_WIDTH'(OPERAND_BASE) + ADDRESS_WIDTH'(idx_d);
                cmd_d.data = ops_d[idx_d[SEL_W-1:0]];
            end
            WR_START: begin
                cmd_d.wr   = 1'b1;
                cmd_d.addr = ADDRESS_WIDTH'(CTRL_ADDR);
                cmd_d.data = 32'h1;
            end
            RD_RESULT: begin
                cmd_d.rd   = 1'b1;
                cmd_d.addr = ADDRESS_WIDTH'(RESULT_ADDR);
            end
            WR_CLEAR: begin
                cmd_d.wr   = 1'b1;
                cmd_d.addr = ADDRESS_WIDTH'(CTRL_ADDR);
                cmd_d.data = 32'h0;
            end
            default: cmd_d = '0;
        endcase
    end

    assign busy                 = (state_q != IDLE);
    assign result               = res_q;
    assign result_valid         = rvld_q;
    assign timeout_err          = terr_q;
    assign bus.master_address   = cmd_q.addr;
    assign bus.master_read      = cmd_q.rd;
    assign bus.master_write     = cmd_q.wr;
    assign bus.master_writedata = cmd_q.data;
endmodule

// File: tb/tb_vector_op_master.sv
// Directed bench for vector_op_master. Instance A talks to a register-file
// slave model with a 256-cycle compute; instance B (TIMEOUT_CYCLES=16) talks
// to a slave that never raises done_irq.
module tb_vector_op_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- instance A ----------------
    vector_op_master_if #(.ADDRESS_WIDTH(3)) bus_a ();
    logic         start_a = 1'b0;
    logic [127:0] ops_a = '0;
    logic         busy_a, rv_a, terr_a, irq_a;
    logic [31:0]  res_a;

    vector_op_master #(.TIMEOUT_CYCLES(1024)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .operands(ops_a), .busy(busy_a),
        .result(res_a), .result_valid(rv_a), .timeout_err(terr_a),
        .bus(bus_a), .done_irq(irq_a)
    );

    logic [31:0] regs_a [0:7];
    logic [31:0] ctrl_a = '0;
    logic [31:0] rreg_a = '0;
    int          cnt_a = 0;
    logic        pend_a = 1'b0;
    logic [35:0] log_a [$];

    assign irq_a = ctrl_a[1];
    assign bus_a.master_readdata = (bus_a.master_address == 3'd1) ? rreg_a : ctrl_a;

    always @(posedge clk) begin
        if (pend_a) begin
            rreg_a <= regs_a[2] + regs_a[3] + regs_a[4] + regs_a[5];
            pend_a <= 1'b0;
        end
        if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) begin
                ctrl_a[1] <= 1'b1;
                pend_a    <= 1'b1;
            end
        end
        if (bus_a.master_write && !bus_a.master_waitrequest) begin
            log_a.push_back({1'b0, bus_a.master_address, bus_a.master_writedata});
            if (bus_a.master_address == 3'd0) begin
                ctrl_a <= bus_a.master_writedata;
                if (bus_a.master_writedata[0]) cnt_a <= 256;
            end else begin
                regs_a[bus_a.master_address] <= bus_a.master_writedata;
            end
        end
        if (bus_a.master_read && !bus_a.master_waitrequest)
            log_a.push_back({1'b1, bus_a.master_address, 32'h0});
    end

    // waitrequest driver plus stall-stability and read/write exclusion checks
    logic        rand_en = 1'b0;
    logic        p_stall = 1'b0;
    logic [2:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic [1:0]  p_cmd = '0;
    int          nv_a = 0;

    always @(negedge clk) begin
        if (rv_a) nv_a++;
        if (p_stall) begin
            chk("stall_addr", bus_a.master_address, p_addr);
            chk("stall_data", bus_a.master_writedata, p_data);
            chk("stall_cmd", {bus_a.master_read, bus_a.master_write}, p_cmd);
        end
        if (bus_a.master_read || bus_a.master_write)
            chk("rw_excl", bus_a.master_read & bus_a.master_write, 0);
        bus_a.master_waitrequest = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
        p_stall = (bus_a.master_read | bus_a.master_write) & bus_a.master_waitrequest;
        p_addr  = bus_a.master_address;
        p_data  = bus_a.master_writedata;
        p_cmd   = {bus_a.master_read, bus_a.master_write};
    end

    // ---------------- instance B (no irq, short watchdog) ----------------
    vector_op_master_if #(.ADDRESS_WIDTH(3)) bus_b ();
    logic         start_b = 1'b0;
    logic [127:0] ops_b = '0;
    logic         busy_b, rv_b, terr_b;
    logic         irq_b = 1'b0;
    logic [31:0]  res_b;
    logic [35:0]  log_b [$];
    int           t_go = 0, t_clr = 0, nv_b = 0;

    assign bus_b.master_waitrequest = 1'b0;
    assign bus_b.master_readdata    = 32'h0;

    vector_op_master #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .operands(ops_b), .busy(busy_b),
        .result(res_b), .result_valid(rv_b), .timeout_err(terr_b),
        .bus(bus_b), .done_irq(irq_b)
    );

    always @(posedge clk) begin
        if (bus_b.master_write) begin
            log_b.push_back({1'b0, bus_b.master_address, bus_b.master_writedata});
            if (bus_b.master_address == 3'd0) begin
                if (bus_b.master_writedata == 32'h1) t_go <= cyc;
                else t_clr <= cyc;
            end
        end
        if (bus_b.master_read) log_b.push_back({1'b1, bus_b.master_address, 32'h0});
    end
    always @(negedge clk) if (rv_b) nv_b++;

    // ---------------- helpers ----------------
    task automatic check_log(input string tag, input logic [31:0] o0, o1, o2, o3);
        logic [35:0] e [7];
        e[0] = {4'h2, o0}; e[1] = {4'h3, o1}; e[2] = {4'h4, o2}; e[3] = {4'h5, o3};
        e[4] = {4'h0, 32'h1}; e[5] = {4'h9, 32'h0}; e[6] = {4'h0, 32'h0};
        chk({tag, "_nxfer"}, log_a.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < log_a.size()) chk($sformatf("%s_xfer%0d", tag, i), log_a[i], e[i]);
    endtask

    task automatic run_job(input string tag, input logic [31:0] o0, o1, o2, o3,
                           input logic [31:0] exp_res, input int exp_lat);
        int n;
        log_a.delete();
        @(negedge clk);
        ops_a = {o3, o2, o1, o0};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 1;
        chk({tag, "_busy"}, busy_a, 1);
        while (!rv_a && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, rv_a, 1);
        if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_result"}, res_a, exp_res);
        chk({tag, "_busy_fall"}, busy_a, 0);
        chk({tag, "_terr"}, terr_a, 0);
        @(negedge clk);
        chk({tag, "_valid_1cyc"}, rv_a, 0);
        check_log(tag, o0, o1, o2, o3);
    endtask

    initial begin
        int n, nv0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", rv_a, 0);
        chk("rst_terr", terr_a, 0);
        chk("rst_cmd", {bus_a.master_read, bus_a.master_write}, 0);
        chk("rst_addr", bus_a.master_address, 0);
        chk("rst_wdata", bus_a.master_writedata, 0);
        chk("rst_result", res_a, 0);
        rst = 1'b1;

        run_job("basic", 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A, 266);
        run_job("ovf", 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h00000000, 0);
        rand_en = 1'b1;
        run_job("stall", 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A, 0);
        rand_en = 1'b0;

        // second start while waiting for the irq must be dropped
        log_a.delete();
        nv0 = nv_a;
        @(negedge clk);
        ops_a = {32'd4, 32'd3, 32'd2, 32'd1};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (ctrl_a != 32'h1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dup_reach_wait", ctrl_a, 32'h1);
        repeat (10) @(negedge clk);
        ops_a = {4{32'd7}};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!rv_a && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("dup_result", res_a, 32'h0000000A);
        repeat (30) @(negedge clk);
        chk("dup_nvalid", nv_a - nv0, 1);
        chk("dup_idle", busy_a, 0);
        check_log("dup", 32'd1, 32'd2, 32'd3, 32'd4);

        // watchdog abort on instance B
        log_b.delete();
        @(negedge clk);
        ops_b = {32'd4, 32'd3, 32'd2, 32'd1};
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_idle", busy_b, 0);
        chk("to_terr", terr_b, 1);
        chk("to_nvalid", nv_b, 0);
        chk("to_result", res_b, 0);
        chk("to_wait_cycles", t_clr - t_go, 17);
        chk("to_nxfer", log_b.size(), 6);
        if (log_b.size() == 6) chk("to_clear_wr", log_b[5], {4'h0, 32'h0});
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("to_terr_cleared", terr_b, 0);
        chk("to_busy2", busy_b, 1);
        n = 0;
        while (busy_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_terr2", terr_b, 1);
        chk("to_nvalid2", nv_b, 0);

        // asynchronous reset while writing operand 2
        log_a.delete();
        @(negedge clk);
        ops_a = {32'd4, 32'd3, 32'd2, 32'd1};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!(bus_a.master_write && bus_a.master_address == 3'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arst_reach_op2", {bus_a.master_write, bus_a.master_address}, {1'b1, 3'd3});
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_cmd", {bus_a.master_read, bus_a.master_write}, 0);
        chk("arst_addr", bus_a.master_address, 0);
        chk("arst_wdata", bus_a.master_writedata, 0);
        chk("arst_result", res_a, 0);
        chk("arst_valid_terr", {rv_a, terr_a}, 0);
        @(negedge clk);
        rst = 1'b1;
        run_job("post_rst", 32'd5, 32'd5, 32'd5, 32'd5, 32'h00000014, 266);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
